// File: rtl/uart_rxtx.sv
// Memory-mapped full-duplex UART with TX/RX FIFOs, a runtime baud divisor,
// optional parity, an optional second TX stop bit and sticky W1C error flags.

module uart_rxtx_fifo #(
  parameter int unsigned Depth = 32
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  logic [7:0] wdata_i,
  input  logic       pop_i,
  output logic [7:0] rdata_o,
  output logic       full_o,
  output logic       empty_o
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [7:0]      mem [Depth];
  logic [PtrW-1:0] wr_ptr, rd_ptr;
  logic [CntW-1:0] count;
  logic            do_push, do_pop;

  assign full_o  = (count == CntW'(Depth));
  assign empty_o = (count == '0);
  assign do_pop  = pop_i && !empty_o;
  // A pop frees the slot in the same cycle, so push+pop on a full FIFO both land.
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PtrW'(Depth - 1)) ? '0 : wr_ptr + PtrW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == PtrW'(Depth - 1)) ? '0 : rd_ptr + PtrW'(1);
      count <= count + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata_i;
  end
endmodule

module uart_rxtx #(
  parameter int unsigned ClockFrequency = 50_000_000,
  parameter int unsigned BaudRate       = 115_200,
  parameter int unsigned TxDepth        = 32,
  parameter int unsigned RxDepth        = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        device_req_i,
  input  logic [31:0] device_addr_i,
  input  logic        device_we_i,
  input  logic [3:0]  device_be_i,
  input  logic [31:0] device_wdata_i,
  output logic        device_rvalid_o,
  output logic [31:0] device_rdata_o,
  output logic        uart_tx_o,
  input  logic        uart_rx_i,
  output logic        irq_o
);
  localparam logic [15:0] DIV_RST = 16'(ClockFrequency / BaudRate);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_e;

  logic [11:0] addr;
  logic        wr, rd, div_wr;
  logic [15:0] div_q;
  logic [2:0]  cfg_q;
  logic [3:0]  err_q, err_set, err_clr;
  logic [7:0]  status;
  logic [31:0] rdata_d;
  logic        unused_bits;

  logic       tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0] tx_head;
  logic       rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0] rx_head;

  state_e      tx_state, rx_state;
  logic [15:0] tx_cnt, rx_cnt;
  logic [2:0]  tx_idx, rx_idx;
  logic [7:0]  tx_sh, rx_sh;
  logic        tx_par_bit, tx_pen, tx_two, tx_stop2, tx_bit_end;
  logic        rx_s1, rx_s2, rx_prev, rx_pen, rx_odd, rx_par_bad;
  logic        rx_tick, rx_stop_end;

  assign addr   = device_addr_i[11:0];
  assign wr     = device_req_i && device_be_i[0] && device_we_i;
  assign rd     = device_req_i && device_be_i[0] && !device_we_i;
  assign div_wr = wr && (addr == 12'h00C);
  assign unused_bits = ^{device_addr_i[31:12], device_be_i[3:1], device_wdata_i[31:16]};

  assign tx_push = wr && (addr == 12'h004);
  assign rx_pop  = rd && (addr == 12'h000);

  uart_rxtx_fifo #(.Depth(TxDepth)) u_tx_fifo (
    .clk_i, .rst_ni, .push_i(tx_push), .wdata_i(device_wdata_i[7:0]), .pop_i(tx_pop),
    .rdata_o(tx_head), .full_o(tx_full), .empty_o(tx_empty)
  );
  uart_rxtx_fifo #(.Depth(RxDepth)) u_rx_fifo (
    .clk_i, .rst_ni, .push_i(rx_push), .wdata_i(rx_sh), .pop_i(rx_pop),
    .rdata_o(rx_head), .full_o(rx_full), .empty_o(rx_empty)
  );

  // err_q: [0] RX_OVF, [1] FRAME_ERR, [2] PARITY_ERR, [3] TX_OVF
  assign status  = {err_q, (tx_state != S_IDLE), !rx_empty, tx_empty, tx_full};
  assign err_clr = (wr && (addr == 12'h008)) ? device_wdata_i[7:4] : 4'b0;
  assign err_set = {tx_push && tx_full && !tx_pop,
                    rx_push && rx_par_bad,
                    rx_stop_end && !rx_s2,
                    rx_push && rx_full && !rx_pop};
  assign irq_o   = !rx_empty || (|err_q);

  always_comb begin
    rdata_d = '0;
    if (rd) begin
      case (addr)
        12'h000: rdata_d = {24'b0, rx_empty ? 8'h00 : rx_head};
        12'h008: rdata_d = {24'b0, status};
        12'h00C: rdata_d = {16'b0, div_q};
        12'h010: rdata_d = {29'b0, cfg_q};
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      device_rvalid_o <= 1'b0;
      device_rdata_o  <= '0;
      div_q           <= DIV_RST;
      cfg_q           <= '0;
      err_q           <= '0;
    end else begin
      device_rvalid_o <= device_req_i;
      device_rdata_o  <= rdata_d;
      if (div_wr) div_q <= (device_wdata_i[15:0] < 16'd4) ? 16'd4 : device_wdata_i[15:0];
      if (wr && (addr == 12'h010)) cfg_q <= device_wdata_i[2:0];
      err_q <= (err_q & ~err_clr) | err_set;
    end
  end

  // ---------------- transmitter ----------------
  assign tx_bit_end = (tx_cnt == div_q - 16'd1);
  assign tx_pop = !tx_empty && ((tx_state == S_IDLE) ||
                  ((tx_state == S_STOP) && tx_bit_end && (!tx_two || tx_stop2)));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state   <= S_IDLE;
      tx_cnt     <= '0;
      tx_idx     <= '0;
      tx_sh      <= '0;
      tx_par_bit <= 1'b0;
      tx_pen     <= 1'b0;
      tx_two     <= 1'b0;
      tx_stop2   <= 1'b0;
      uart_tx_o  <= 1'b1;
    end else begin
      if ((tx_state == S_IDLE) || tx_bit_end || div_wr) tx_cnt <= '0;
      else tx_cnt <= tx_cnt + 16'd1;
      case (tx_state)
        S_IDLE: ;
        S_START: if (tx_bit_end) begin
          tx_state  <= S_DATA;
          tx_idx    <= '0;
          uart_tx_o <= tx_sh[0];
        end
        S_DATA: if (tx_bit_end) begin
          if (tx_idx == 3'd7) begin
            tx_state  <= tx_pen ? S_PARITY : S_STOP;
            uart_tx_o <= tx_pen ? tx_par_bit : 1'b1;
            tx_stop2  <= 1'b0;
          end else begin
            tx_sh     <= tx_sh >> 1;
            uart_tx_o <= tx_sh[1];
            tx_idx    <= tx_idx + 3'd1;
          end
        end
        S_PARITY: if (tx_bit_end) begin
          tx_state  <= S_STOP;
          uart_tx_o <= 1'b1;
        end
        S_STOP: if (tx_bit_end) begin
          if (tx_two && !tx_stop2) tx_stop2 <= 1'b1;
          else tx_state <= S_IDLE;
        end
        default: tx_state <= S_IDLE;
      endcase
      // Frame start is shared by IDLE and end-of-STOP; tx_pop fires exactly there.
      if (tx_pop) begin
        tx_state   <= S_START;
        uart_tx_o  <= 1'b0;
        tx_sh      <= tx_head;
        tx_par_bit <= (^tx_head) ^ cfg_q[1];
        tx_pen     <= cfg_q[0];
        tx_two     <= cfg_q[2];
      end
    end
  end

  // ---------------- receiver ----------------
  assign rx_tick     = (rx_state == S_START) ? (rx_cnt == {1'b0, div_q[15:1]} - 16'd1)
                                             : (rx_cnt == div_q - 16'd1);
  assign rx_stop_end = (rx_state == S_STOP) && rx_tick;
  assign rx_push     = rx_stop_end && rx_s2;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_prev    <= 1'b1;
      rx_state   <= S_IDLE;
      rx_cnt     <= '0;
      rx_idx     <= '0;
      rx_sh      <= '0;
      rx_pen     <= 1'b0;
      rx_odd     <= 1'b0;
      rx_par_bad <= 1'b0;
    end else begin
      rx_s1   <= uart_rx_i;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      if ((rx_state == S_IDLE) || (rx_state == S_BREAK) || rx_tick || div_wr) rx_cnt <= '0;
      else rx_cnt <= rx_cnt + 16'd1;
      case (rx_state)
        S_IDLE: if (rx_prev && !rx_s2) begin
          rx_state   <= S_START;
          rx_pen     <= cfg_q[0];
          rx_odd     <= cfg_q[1];
          rx_par_bad <= 1'b0;
        end
        S_START: if (rx_tick) begin
          rx_state <= rx_s2 ? S_IDLE : S_DATA;
          rx_idx   <= '0;
        end
        S_DATA: if (rx_tick) begin
          rx_sh  <= {rx_s2, rx_sh[7:1]};
          rx_idx <= rx_idx + 3'd1;
          if (rx_idx == 3'd7) rx_state <= rx_pen ? S_PARITY : S_STOP;
        end
        S_PARITY: if (rx_tick) begin
          rx_par_bad <= rx_s2 != ((^rx_sh) ^ rx_odd);
          rx_state   <= S_STOP;
        end
        S_STOP:  if (rx_tick) rx_state <= rx_s2 ? S_IDLE : S_BREAK;
        S_BREAK: if (rx_s2) rx_state <= S_IDLE;
        default: rx_state <= S_IDLE;
      endcase
    end
  end
endmodule
